alu_controller: RTL and testbench

Instruction-to-ALU-operation decoder for the MIPS datapath. Examines opcode, funct, rs[0], shamt[0] and shamt of the 32-bit instruction word and produces the 5-bit ALUOp code consumed by the ALU. Sits in the decode stage. Provides a zero-latency combinational output for single-cycle use and a registered copy for the ID/EX pipeline boundary.

---
 rtl/alu_pkg.sv | 78 +++++++
 rtl/alu_op_decode.sv | 81 ++++++++
 rtl/alu_controller.sv | 29 ++
 tb/tb_alu_controller.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU operation codes and MIPS opcode/funct field constants.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 5;
  localparam int unsigned OPC_W    = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned SHAMT_W  = 5;

  // ALU operation codes
  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 5'b00000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 5'b00001;
  localparam logic [ALU_OP_W-1:0] ALU_MUL   = 5'b00010;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 5'b00011;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 5'b00100;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 5'b00101;
  localparam logic [ALU_OP_W-1:0] ALU_NOR   = 5'b00110;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 5'b00111;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 5'b01000;
  localparam logic [ALU_OP_W-1:0] ALU_ROTR  = 5'b01001;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 5'b01010;
  localparam logic [ALU_OP_W-1:0] ALU_SEH   = 5'b01011;
  localparam logic [ALU_OP_W-1:0] ALU_ADDU  = 5'b01100;
  localparam logic [ALU_OP_W-1:0] ALU_MULTU = 5'b01101;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 5'b01110;
  localparam logic [ALU_OP_W-1:0] ALU_SEB   = 5'b01111;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 5'b10000;
  localparam logic [ALU_OP_W-1:0] ALU_SLLV  = 5'b10001;
  localparam logic [ALU_OP_W-1:0] ALU_SRLV  = 5'b10010;
  localparam logic [ALU_OP_W-1:0] ALU_SRAV  = 5'b10011;
  localparam logic [ALU_OP_W-1:0] ALU_ROTRV = 5'b10100;
  localparam logic [ALU_OP_W-1:0] ALU_MOV   = 5'b10101;

  // Opcodes
  localparam logic [OPC_W-1:0] OPC_SPECIAL  = 6'b000000;
  localparam logic [OPC_W-1:0] OPC_ADDI     = 6'b001000;
  localparam logic [OPC_W-1:0] OPC_ADDIU    = 6'b001001;
  localparam logic [OPC_W-1:0] OPC_SLTI     = 6'b001010;
  localparam logic [OPC_W-1:0] OPC_SLTIU    = 6'b001011;
  localparam logic [OPC_W-1:0] OPC_ANDI     = 6'b001100;
  localparam logic [OPC_W-1:0] OPC_ORI      = 6'b001101;
  localparam logic [OPC_W-1:0] OPC_XORI     = 6'b001110;
  localparam logic [OPC_W-1:0] OPC_SPECIAL2 = 6'b011100;
  localparam logic [OPC_W-1:0] OPC_SPECIAL3 = 6'b011111;

  // SPECIAL funct codes
  localparam logic [FUNCT_W-1:0] FN_SLL   = 6'b000000;
  localparam logic [FUNCT_W-1:0] FN_SRL   = 6'b000010;
  localparam logic [FUNCT_W-1:0] FN_SRA   = 6'b000011;
  localparam logic [FUNCT_W-1:0] FN_SLLV  = 6'b000100;
  localparam logic [FUNCT_W-1:0] FN_SRLV  = 6'b000110;
  localparam logic [FUNCT_W-1:0] FN_SRAV  = 6'b000111;
  localparam logic [FUNCT_W-1:0] FN_MOVZ  = 6'b001010;
  localparam logic [FUNCT_W-1:0] FN_MOVN  = 6'b001011;
  localparam logic [FUNCT_W-1:0] FN_MUL   = 6'b011000;
  localparam logic [FUNCT_W-1:0] FN_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FN_ADD   = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_ADDU  = 6'b100001;
  localparam logic [FUNCT_W-1:0] FN_SUB   = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND   = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR    = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_XOR   = 6'b100110;
  localparam logic [FUNCT_W-1:0] FN_NOR   = 6'b100111;
  localparam logic [FUNCT_W-1:0] FN_SLT   = 6'b101010;
  localparam logic [FUNCT_W-1:0] FN_SLTU  = 6'b101011;

  // SPECIAL2 funct codes
  localparam logic [FUNCT_W-1:0] FN2_MADD  = 6'b000000;
  localparam logic [FUNCT_W-1:0] FN2_MADDU = 6'b000001;
  localparam logic [FUNCT_W-1:0] FN2_MUL   = 6'b000010;
  localparam logic [FUNCT_W-1:0] FN2_MSUB  = 6'b000100;
  localparam logic [FUNCT_W-1:0] FN2_MSUBU = 6'b000101;

  // SPECIAL3 BSHFL funct and shamt selectors
  localparam logic [FUNCT_W-1:0] FN3_BSHFL = 6'b100000;
  localparam logic [SHAMT_W-1:0] SA_SEB    = 5'b10000;
  localparam logic [SHAMT_W-1:0] SA_SEH    = 5'b11000;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational instruction word to ALU operation code decode.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0]         i_instr,
  output logic [ALU_OP_W-1:0] o_aluop
);

  logic [OPC_W-1:0]   w_op;
  logic [FUNCT_W-1:0] w_funct;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_rs0;
  logic               w_unused;

  assign w_op     = i_instr[31:26];
  assign w_funct  = i_instr[5:0];
  assign w_shamt  = i_instr[10:6];
  assign w_rs0    = i_instr[21];
  assign w_unused = ^{i_instr[25:22], i_instr[20:11]};

  // Decode opcode, then funct/sub-fields; anything unrecognised maps to ADD
  always_comb begin
    o_aluop = ALU_ADD;
    case (w_op)
      OPC_SPECIAL: begin
        case (w_funct)
          FN_ADD:   o_aluop = ALU_ADD;
          FN_ADDU:  o_aluop = ALU_ADDU;
          FN_SUB:   o_aluop = ALU_SUB;
          FN_AND:   o_aluop = ALU_AND;
          FN_OR:    o_aluop = ALU_OR;
          FN_XOR:   o_aluop = ALU_XOR;
          FN_NOR:   o_aluop = ALU_NOR;
          FN_SLT:   o_aluop = ALU_SLT;
          FN_SLTU:  o_aluop = ALU_SLTU;
          FN_MUL:   o_aluop = ALU_MUL;
          FN_MULTU: o_aluop = ALU_MULTU;
          FN_SLL:   o_aluop = ALU_SLL;
          // rs[0] distinguishes rotr from srl
          FN_SRL:   o_aluop = w_rs0 ? ALU_ROTR : ALU_SRL;
          FN_SRA:   o_aluop = ALU_SRA;
          FN_SLLV:  o_aluop = ALU_SLLV;
          FN_SRAV:  o_aluop = ALU_SRAV;
          // shamt[0] distinguishes rotrv from srlv
          FN_SRLV:  o_aluop = w_shamt[0] ? ALU_ROTRV : ALU_SRLV;
          FN_MOVZ,
          FN_MOVN:  o_aluop = ALU_MOV;
          default:  o_aluop = ALU_ADD;
        endcase
      end
      OPC_ADDI:  o_aluop = ALU_ADD;
      OPC_ADDIU: o_aluop = ALU_ADDU;
      OPC_SLTI:  o_aluop = ALU_SLT;
      OPC_SLTIU: o_aluop = ALU_SLTU;
      OPC_ANDI:  o_aluop = ALU_AND;
      OPC_ORI:   o_aluop = ALU_OR;
      OPC_XORI:  o_aluop = ALU_XOR;
      OPC_SPECIAL2: begin
        case (w_funct)
          FN2_MADD,
          FN2_MUL,
          FN2_MSUB:  o_aluop = ALU_MUL;
          FN2_MADDU,
          FN2_MSUBU: o_aluop = ALU_MULTU;
          default:   o_aluop = ALU_ADD;
        endcase
      end
      OPC_SPECIAL3: begin
        if (w_funct == FN3_BSHFL) begin
          case (w_shamt)
            SA_SEB:  o_aluop = ALU_SEB;
            SA_SEH:  o_aluop = ALU_SEH;
            default: o_aluop = ALU_ADD;
          endcase
        end
      end
      default: o_aluop = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_controller.sv
// ALU controller: combinational decode plus an async-reset registered copy.
module alu_controller
  import alu_pkg::*;
(
  input  logic                Clk,
  input  logic                Rst,
  input  logic [31:0]         Instruction,
  output logic [ALU_OP_W-1:0] ALUOp,
  output logic [ALU_OP_W-1:0] ALUOpReg
);

  logic [ALU_OP_W-1:0] w_aluop;
  logic [ALU_OP_W-1:0] r_aluop;

  alu_op_decode u_decode (
    .i_instr (Instruction),
    .o_aluop (w_aluop)
  );

  // Capture the decode every cycle; reset clears immediately
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) r_aluop <= ALU_ADD;
    else     r_aluop <= w_aluop;
  end

  assign ALUOp    = w_aluop;
  assign ALUOpReg = r_aluop;

endmodule

// File: tb/tb_alu_controller.sv
// Scoreboard bench for alu_controller with a rule-table reference model.
module tb_alu_controller;

  logic        Clk;
  logic        Rst;
  logic [31:0] Instruction;
  logic [4:0]  ALUOp;
  logic [4:0]  ALUOpReg;

  int n_cmp;
  int n_bad;

  alu_controller dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Instruction (Instruction),
    .ALUOp       (ALUOp),
    .ALUOpReg    (ALUOpReg)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference: ordered list of (mask, match, code); first hit wins, else ADD
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  code;
  } rule_t;

  rule_t rules[$];

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  exp_op;
    logic [4:0]  exp_reg;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] M_FN   = 32'hFC00_003F;
  localparam logic [31:0] M_OP   = 32'hFC00_0000;
  localparam logic [31:0] M_S3   = 32'hFC00_07FF;
  localparam logic [31:0] B_RS0  = 32'h0020_0000;
  localparam logic [31:0] B_SH0  = 32'h0000_0040;

  function automatic logic [31:0] opf(input logic [5:0] o);
    return {o, 26'd0};
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] o, input logic [4:0] rs,
                                     input logic [4:0] sa, input logic [5:0] fn);
    return {o, rs, 5'd3, 5'd9, sa, fn};
  endfunction

  task automatic add_rule(input logic [31:0] m, input logic [31:0] v, input logic [4:0] c);
    rule_t r;
    r.mask = m; r.match = v; r.code = c;
    rules.push_back(r);
  endtask

  function automatic logic [4:0] ref_op(input logic [31:0] ins);
    foreach (rules[i])
      if ((ins & rules[i].mask) == rules[i].match) return rules[i].code;
    return 5'd0;
  endfunction

  task automatic build_rules();
    // SPECIAL, specific disambiguations first
    add_rule(M_FN | B_RS0, 32'h0000_0002 | B_RS0, 5'd9);   // rotr
    add_rule(M_FN | B_SH0, 32'h0000_0006 | B_SH0, 5'd20);  // rotrv
    add_rule(M_FN, 32'd32, 5'd0);   add_rule(M_FN, 32'd33, 5'd12);
    add_rule(M_FN, 32'd34, 5'd1);   add_rule(M_FN, 32'd36, 5'd3);
    add_rule(M_FN, 32'd37, 5'd4);   add_rule(M_FN, 32'd38, 5'd5);
    add_rule(M_FN, 32'd39, 5'd6);   add_rule(M_FN, 32'd42, 5'd14);
    add_rule(M_FN, 32'd43, 5'd16);  add_rule(M_FN, 32'd24, 5'd2);
    add_rule(M_FN, 32'd25, 5'd13);  add_rule(M_FN, 32'd0,  5'd7);
    add_rule(M_FN, 32'd2,  5'd8);   add_rule(M_FN, 32'd3,  5'd10);
    add_rule(M_FN, 32'd4,  5'd17);  add_rule(M_FN, 32'd7,  5'd19);
    add_rule(M_FN, 32'd6,  5'd18);  add_rule(M_FN, 32'd10, 5'd21);
    add_rule(M_FN, 32'd11, 5'd21);
    // I-type
    add_rule(M_OP, opf(6'd8),  5'd0);  add_rule(M_OP, opf(6'd9),  5'd12);
    add_rule(M_OP, opf(6'd10), 5'd14); add_rule(M_OP, opf(6'd11), 5'd16);
    add_rule(M_OP, opf(6'd12), 5'd3);  add_rule(M_OP, opf(6'd13), 5'd4);
    add_rule(M_OP, opf(6'd14), 5'd5);
    // SPECIAL2
    add_rule(M_FN, opf(6'd28) | 32'd0, 5'd2);
    add_rule(M_FN, opf(6'd28) | 32'd2, 5'd2);
    add_rule(M_FN, opf(6'd28) | 32'd4, 5'd2);
    add_rule(M_FN, opf(6'd28) | 32'd1, 5'd13);
    add_rule(M_FN, opf(6'd28) | 32'd5, 5'd13);
    // SPECIAL3 BSHFL
    add_rule(M_S3, opf(6'd31) | (32'd16 << 6) | 32'd32, 5'd15);
    add_rule(M_S3, opf(6'd31) | (32'd24 << 6) | 32'd32, 5'd11);
  endtask

  // Register model: value captured at the most recent rising edge
  logic [4:0] r_model;

  // One cycle: edge captures current word, then drive new word/reset and log expectations
  task automatic step(input logic [31:0] ins, input logic rst_v);
    exp_t e;
    @(posedge Clk);
    r_model = Rst ? 5'd0 : ref_op(Instruction);
    #1;
    Instruction = ins;
    Rst = rst_v;
    if (rst_v) r_model = 5'd0;
    e.ins = ins; e.exp_op = ref_op(ins); e.exp_reg = r_model;
    sb.push_back(e);
  endtask

  // Monitor: outputs settled mid-cycle, compare against oldest expectation
  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp = n_cmp + 2;
      if (ALUOp !== e.exp_op) begin
        n_bad = n_bad + 1;
        $display("FAIL aluop ins=%08h got=%05b want=%05b", e.ins, ALUOp, e.exp_op);
      end
      if (ALUOpReg !== e.exp_reg) begin
        n_bad = n_bad + 1;
        $display("FAIL aluopreg ins=%08h got=%05b want=%05b", e.ins, ALUOpReg, e.exp_reg);
      end
    end
  end

  logic [5:0] r_fns[$] = '{6'd32, 6'd33, 6'd36, 6'd39, 6'd37, 6'd42, 6'd43, 6'd34,
                           6'd38, 6'd24, 6'd25, 6'd0, 6'd4, 6'd3, 6'd7, 6'd10, 6'd11};
  logic [5:0] ops[$]   = '{6'd0, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14,
                           6'd28, 6'd31, 6'd35, 6'd43, 6'd4, 6'd2, 6'd15};

  initial begin
    int budget;
    logic [31:0] w;
    n_cmp = 0;
    n_bad = 0;
    Rst = 1'b1;
    Instruction = 32'd0;
    r_model = 5'd0;
    build_rules();

    // Reset held: register stays zero while comb output follows the word
    step(mk(6'd0, 5'd1, 5'd2, 6'd34), 1'b1);
    step(mk(6'd0, 5'd0, 5'd0, 6'd39), 1'b1);
    // Release with sub, then directed sweep
    step(mk(6'd0, 5'd4, 5'd0, 6'd34), 1'b0);
    foreach (r_fns[i]) step(mk(6'd0, 5'd2, 5'd4, r_fns[i]), 1'b0);
    step(mk(6'd0, 5'd1, 5'd0, 6'd2), 1'b0);
    step(mk(6'd0, 5'd0, 5'd0, 6'd2), 1'b0);
    step(mk(6'd0, 5'd0, 5'd1, 6'd6), 1'b0);
    step(mk(6'd0, 5'd0, 5'd0, 6'd6), 1'b0);
    step(32'd0, 1'b0);
    for (int o = 8; o <= 14; o++) step(mk(6'(o), 5'd5, 5'd7, 6'd1), 1'b0);
    step(mk(6'd28, 5'd1, 5'd0, 6'd2), 1'b0);
    step(mk(6'd28, 5'd1, 5'd0, 6'd0), 1'b0);
    step(mk(6'd28, 5'd1, 5'd0, 6'd4), 1'b0);
    step(mk(6'd28, 5'd1, 5'd0, 6'd1), 1'b0);
    step(mk(6'd28, 5'd1, 5'd0, 6'd5), 1'b0);
    step(mk(6'd31, 5'd0, 5'd16, 6'd32), 1'b0);
    step(mk(6'd31, 5'd0, 5'd24, 6'd32), 1'b0);
    step(mk(6'd31, 5'd0, 5'd17, 6'd32), 1'b0);
    step(mk(6'd35, 5'd1, 5'd1, 6'd34), 1'b0);
    // Mid-cycle reset pulse after a non-zero decode
    step(mk(6'd0, 5'd0, 5'd0, 6'd39), 1'b0);
    step(mk(6'd0, 5'd0, 5'd0, 6'd37), 1'b1);
    step(mk(6'd0, 5'd0, 5'd0, 6'd34), 1'b0);
    step(mk(6'd0, 5'd0, 5'd0, 6'd36), 1'b0);

    // Randomised words biased toward decoded opcodes/functs
    for (int k = 0; k < 300; k++) begin
      w = $urandom;
      if ($urandom_range(3) != 0) w[31:26] = ops[$urandom_range(ops.size() - 1)];
      if ($urandom_range(2) != 0) w[5:0] = r_fns[$urandom_range(r_fns.size() - 1)];
      else if ($urandom_range(1) != 0) w[5:0] = 6'($urandom_range(7));
      if (w[31:26] == 6'd31 && $urandom_range(1) != 0) begin
        w[5:0] = 6'd32;
        w[10:6] = ($urandom_range(1) != 0) ? 5'd16 : 5'd24;
      end
      step(w, ($urandom_range(19) == 0) ? 1'b1 : 1'b0);
    end

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge Clk);
      budget++;
    end
    if (sb.size() > 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
